uart_fifo_mmio: RTL and testbench

Parametrised memory-mapped UART that supersedes the fixed single-byte UART peripheral on the CPU data bus. It adds independent TX/RX FIFOs, a runtime-programmable baud divisor, sticky error flags, a control register and a level interrupt. It sits behind `mem_manager` on the `en`/`we`/`addr`/`wdata`/`rdata` port group and drives the board USB-UART pins. Register reads are combinational so the single-cycle CPU completes a load in one cycle.

---
 rtl/uart_fifo_mmio.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_mmio.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_mmio.sv
// Memory-mapped UART with TX/RX FIFOs, programmable baud divisor, sticky error
// flags and a level interrupt. Register reads are combinational for single-cycle loads.
module uart_fifo_mmio #(
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int DIV_RESET = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int BW    = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_BAUD   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [1:0] reg_sel;
    logic       wr_data, wr_status, wr_ctrl, wr_baud, rd_data;
    logic       unused_bits;

    assign reg_sel     = addr[3:2];
    assign wr_data     = en & we & (reg_sel == A_DATA);
    assign wr_status   = en & we & (reg_sel == A_STATUS);
    assign wr_ctrl     = en & we & (reg_sel == A_CTRL);
    assign wr_baud     = en & we & (reg_sel == A_BAUD);
    assign rd_data     = en & ~we & (reg_sel == A_DATA);
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

    logic [3:0]  ctrl_reg;
    logic [15:0] baud_reg;
    logic        overrun_reg, frame_err_reg;
    logic        tx_en, rx_en, irq_rx_en, irq_tx_en;

    assign tx_en     = ctrl_reg[0];
    assign rx_en     = ctrl_reg[1];
    assign irq_rx_en = ctrl_reg[2];
    assign irq_tx_en = ctrl_reg[3];

    // TX FIFO
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW:0]       tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic                 tx_full, tx_empty, tx_push, tx_pop;

    assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    assign tx_full  = (tx_wr_ptr_reg[TX_AW] != tx_rd_ptr_reg[TX_AW]) &&
                      (tx_wr_ptr_reg[TX_AW-1:0] == tx_rd_ptr_reg[TX_AW-1:0]);
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign tx_push  = wr_data & (~tx_full | tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg[TX_AW-1:0]] <= wdata[DATA_BITS-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
        end
    end

    // RX FIFO
    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW:0]       rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic                 rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]           rx_count;
    logic [DATA_BITS-1:0] rx_shift_reg;

    assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
    assign rx_full  = (rx_wr_ptr_reg[RX_AW] != rx_rd_ptr_reg[RX_AW]) &&
                      (rx_wr_ptr_reg[RX_AW-1:0] == rx_rd_ptr_reg[RX_AW-1:0]);
    assign rx_count = 8'(rx_wr_ptr_reg - rx_rd_ptr_reg);
    assign rx_pop   = rd_data & ~rx_empty;

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr_reg[RX_AW-1:0]] <= rx_shift_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
        end
    end

    // TX engine
    state_t               tx_state_reg;
    logic [15:0]          tx_div_reg, tx_cnt_reg;
    logic [BW-1:0]        tx_bit_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic                 tx_out_reg, tx_tick, tx_busy;

    assign tx_tick = (tx_cnt_reg == 16'd0);
    assign tx_busy = (tx_state_reg != S_IDLE);
    assign tx_pop  = tx_en & ~tx_empty &
                     ((tx_state_reg == S_IDLE) | ((tx_state_reg == S_STOP) & tx_tick));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_reg <= S_IDLE;
            tx_div_reg   <= 16'(DIV_RESET);
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_out_reg   <= 1'b1;
        end else if (tx_pop) begin
            tx_state_reg <= S_START;
            tx_shift_reg <= tx_mem[tx_rd_ptr_reg[TX_AW-1:0]];
            tx_div_reg   <= baud_reg;
            tx_cnt_reg   <= baud_reg - 16'd1;
            tx_out_reg   <= 1'b0;
        end else begin
            case (tx_state_reg)
                S_IDLE: tx_out_reg <= 1'b1;
                S_START: begin
                    if (tx_tick) begin
                        tx_state_reg <= S_DATA;
                        tx_out_reg   <= tx_shift_reg[0];
                        tx_shift_reg <= tx_shift_reg >> 1;
                        tx_bit_reg   <= '0;
                        tx_cnt_reg   <= tx_div_reg - 16'd1;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_tick) begin
                        tx_cnt_reg <= tx_div_reg - 16'd1;
                        if (tx_bit_reg == LAST_BIT) begin
                            tx_state_reg <= S_STOP;
                            tx_out_reg   <= 1'b1;
                        end else begin
                            tx_out_reg   <= tx_shift_reg[0];
                            tx_shift_reg <= tx_shift_reg >> 1;
                            tx_bit_reg   <= tx_bit_reg + BW'(1);
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                S_STOP: begin
                    if (tx_tick) tx_state_reg <= S_IDLE;
                    else         tx_cnt_reg   <= tx_cnt_reg - 16'd1;
                end
            endcase
        end
    end

    assign uart_tx = tx_out_reg;

    // RX synchroniser plus one extra stage for falling-edge detection
    logic [1:0] rx_sync_reg;
    logic       rx_prev_reg, rx_s;

    assign rx_s = rx_sync_reg[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_reg <= 2'b11;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_sync_reg <= {rx_sync_reg[0], uart_rx};
            rx_prev_reg <= rx_s;
        end
    end

    // RX engine
    state_t        rx_state_reg;
    logic [15:0]   rx_div_reg, rx_cnt_reg;
    logic [BW-1:0] rx_bit_reg;
    logic          rx_tick, rx_stop_sample, rx_stop_ok, frame_err_set, overrun_set;

    assign rx_tick        = (rx_cnt_reg == 16'd0);
    assign rx_stop_sample = rx_en & (rx_state_reg == S_STOP) & rx_tick;
    assign rx_stop_ok     = rx_stop_sample & rx_s;
    assign frame_err_set  = rx_stop_sample & ~rx_s;
    assign rx_push        = rx_stop_ok & (~rx_full | rx_pop);
    assign overrun_set    = rx_stop_ok & rx_full & ~rx_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_reg <= S_IDLE;
            rx_div_reg   <= 16'(DIV_RESET);
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else if (!rx_en) begin
            rx_state_reg <= S_IDLE;
        end else begin
            case (rx_state_reg)
                S_IDLE: begin
                    if (rx_prev_reg & ~rx_s) begin
                        rx_state_reg <= S_START;
                        rx_div_reg   <= baud_reg;
                        rx_cnt_reg   <= {1'b0, baud_reg[15:1]} - 16'd1;
                    end
                end
                S_START: begin
                    if (rx_tick) begin
                        rx_state_reg <= rx_s ? S_IDLE : S_DATA;
                        rx_bit_reg   <= '0;
                        rx_cnt_reg   <= rx_div_reg - 16'd1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_shift_reg <= {rx_s, rx_shift_reg[DATA_BITS-1:1]};
                        rx_cnt_reg   <= rx_div_reg - 16'd1;
                        if (rx_bit_reg == LAST_BIT) rx_state_reg <= S_STOP;
                        else                        rx_bit_reg   <= rx_bit_reg + BW'(1);
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_tick) rx_state_reg <= S_IDLE;
                    else         rx_cnt_reg   <= rx_cnt_reg - 16'd1;
                end
            endcase
        end
    end

    // Control, divisor and sticky flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_reg      <= 4'h3;
            baud_reg      <= 16'(DIV_RESET);
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_reg <= wdata[3:0];
            if (wr_baud) baud_reg <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
            overrun_reg   <= overrun_set   | (overrun_reg   & ~(wr_status & wdata[4]));
            frame_err_reg <= frame_err_set | (frame_err_reg & ~(wr_status & wdata[5]));
        end
    end

    always_comb begin
        rdata = '0;
        if (en && !we) begin
            case (reg_sel)
                A_DATA: begin
                    if (!rx_empty) rdata[DATA_BITS-1:0] = rx_mem[rx_rd_ptr_reg[RX_AW-1:0]];
                end
                A_STATUS: rdata = {16'd0, rx_count, 1'b0, tx_busy, frame_err_reg, overrun_reg,
                                   rx_full, rx_empty, tx_empty, tx_full};
                A_CTRL:   rdata = {28'd0, ctrl_reg};
                A_BAUD:   rdata = {16'd0, baud_reg};
            endcase
        end
    end

    assign irq = (irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty) | overrun_reg | frame_err_reg;

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Self-checking bench for uart_fifo_mmio: TX bytes are checked by a serial monitor
// against a queue of written bytes, RX bytes against a queue of driven frames.
module tb_uart_fifo_mmio;
    localparam int DIV = 4;
    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_BAUD   = 32'hC;

    logic        clk = 1'b0;
    logic        rst, en, we;
    logic [31:0] addr, wdata, rdata;
    logic        uart_rx, uart_tx, irq;
    logic        rx_drv, loopback, mon_en, b2b_mode;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];

    uart_fifo_mmio dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign uart_rx = loopback ? uart_tx : rx_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        en = 1'b1; we = 1'b0; addr = a;
        #1 d = rdata;
        @(negedge clk);
        en = 1'b0; addr = '0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            rx_drv = f[b];
            repeat (DIV) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic wait_tx(input int limit);
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("tx_drain_timeout", 32'(tx_q.size()), 0);
    endtask

    // Serial TX monitor: each bit must hold for exactly DIV cycles
    initial begin : tx_mon
        logic [9:0] bits;
        logic       unstable, b2b_seen;
        int         start_cyc, prev_cyc;
        b2b_seen = 1'b0;
        prev_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && mon_en && uart_tx === 1'b0) begin
                start_cyc = cyc;
                unstable  = 1'b0;
                bits      = '0;
                if (b2b_mode && b2b_seen)
                    check("tx_gap", 32'(start_cyc - prev_cyc), 32'(10 * DIV));
                prev_cyc = start_cyc;
                b2b_seen = b2b_mode;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < DIV; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (s == 0) bits[b] = uart_tx;
                        else if (uart_tx !== bits[b]) unstable = 1'b1;
                    end
                end
                check("tx_bit_width", {31'd0, unstable}, 0);
                check("tx_start_bit", {31'd0, bits[0]}, 0);
                check("tx_stop_bit", {31'd0, bits[9]}, 1);
                check("tx_frame_expected", 32'(tx_q.size() > 0), 1);
                if (tx_q.size() > 0)
                    check("tx_byte", {24'd0, bits[8:1]}, {24'd0, tx_q.pop_front()});
            end
        end
    end

    initial begin : main
        logic [31:0] rd;
        logic [7:0]  b;
        int          model_cnt;
        rst = 1'b0; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        rx_drv = 1'b1; loopback = 1'b0; mon_en = 1'b1; b2b_mode = 1'b0;

        // Reset values
        idle(3);
        check("reset_uart_tx", {31'd0, uart_tx}, 1);
        check("reset_irq", {31'd0, irq}, 0);
        rst = 1'b1;
        idle(1);
        check("rdata_not_selected", rdata, 0);
        bus_read(A_STATUS, rd); check("reset_status", rd, 32'h6);
        bus_read(A_CTRL, rd);   check("reset_ctrl", rd, 32'h3);
        bus_read(A_BAUD, rd);   check("reset_bauddiv", rd, 32'd868);

        // Divisor clamp, then single TX frame with latency checks
        bus_write(A_BAUD, 32'd1);
        bus_read(A_BAUD, rd);   check("baud_min_clamp", rd, 32'd4);
        bus_write(A_BAUD, 32'(DIV));
        bus_read(A_BAUD, rd);   check("baud_write", rd, 32'(DIV));
        tx_q.push_back(8'hA5);
        bus_write(A_DATA, 32'hA5);
        check("tx_latency_edge_n", {31'd0, uart_tx}, 1);
        idle(1);
        check("tx_latency_edge_n1", {31'd0, uart_tx}, 0);
        bus_read(A_STATUS, rd); check("tx_busy_mid_frame", {31'd0, rd[6]}, 1);
        wait_tx(100);
        bus_read(A_STATUS, rd); check("tx_done_status", rd, 32'h6);

        // Fill TX FIFO with TX disabled, 17th byte dropped, then back-to-back frames
        bus_write(A_CTRL, 32'h2);
        model_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            if (model_cnt < 16) begin
                tx_q.push_back(8'(i));
                model_cnt++;
            end
            bus_write(A_DATA, 32'(i));
            if (i == 15) begin
                bus_read(A_STATUS, rd); check("tx_full_after_16", {31'd0, rd[0]}, 1);
            end
        end
        bus_read(A_STATUS, rd); check("tx_full_status", rd, 32'h5);
        b2b_mode = 1'b1;
        bus_write(A_CTRL, 32'h3);
        wait_tx(16 * 10 * DIV + 100);
        b2b_mode = 1'b0;
        bus_read(A_STATUS, rd); check("tx_b2b_done_status", rd, 32'h6);

        // Loopback
        loopback = 1'b1;
        tx_q.push_back(8'h3C);
        rx_q.push_back(8'h3C);
        bus_write(A_DATA, 32'h3C);
        wait_tx(100);
        idle(10);
        loopback = 1'b0;
        bus_read(A_STATUS, rd); check("loop_status_count1", rd, 32'h0102);
        bus_read(A_DATA, rd);   check("loop_rx_byte", rd, {24'd0, rx_q.pop_front()});
        bus_read(A_STATUS, rd); check("loop_rx_empty", {31'd0, rd[2]}, 1);

        // Framing error and W1C
        send_frame(8'h55, 1'b0);
        idle(8);
        bus_read(A_STATUS, rd); check("frame_err_status", rd, 32'h26);
        check("frame_err_irq", {31'd0, irq}, 1);
        bus_write(A_STATUS, 32'h20);
        bus_read(A_STATUS, rd); check("frame_err_cleared", rd, 32'h6);
        check("irq_after_clear", {31'd0, irq}, 0);

        // One-cycle glitch is a false start
        @(negedge clk); rx_drv = 1'b0;
        @(negedge clk); rx_drv = 1'b1;
        idle(20);
        bus_read(A_STATUS, rd); check("glitch_no_push", rd, 32'h6);

        // Disabling RX mid-byte discards the partial frame
        fork
            send_frame(8'h81, 1'b1);
            begin
                repeat (16) @(negedge clk);
                bus_write(A_CTRL, 32'h1);
            end
        join
        bus_write(A_CTRL, 32'h3);
        idle(4);
        bus_read(A_STATUS, rd); check("rx_disable_no_push", rd, 32'h6);

        // Overrun: 17 frames without reading
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 13 + 5);
            if (i < 16) rx_q.push_back(b);
            send_frame(b, 1'b1);
        end
        idle(8);
        bus_read(A_STATUS, rd); check("overrun_status", rd, 32'h101A);
        check("overrun_irq", {31'd0, irq}, 1);
        bus_write(A_STATUS, 32'h10);
        bus_read(A_STATUS, rd); check("overrun_cleared", rd, 32'h100A);
        check("irq_rx_disabled", {31'd0, irq}, 0);
        bus_write(A_CTRL, 32'h7);
        check("irq_rx_enabled", {31'd0, irq}, 1);
        bus_write(A_CTRL, 32'h3);

        // CPU pop coincides with the STOP-sample push on a full RX FIFO
        rx_q.push_back(8'hE7);
        idle(2);
        fork
            send_frame(8'hE7, 1'b1);
            begin
                repeat (40) @(negedge clk);
                bus_read(A_DATA, rd);
            end
        join
        check("simul_pop_byte", rd, {24'd0, rx_q.pop_front()});
        idle(4);
        bus_read(A_STATUS, rd); check("simul_full_no_overrun", rd, 32'h100A);
        for (int i = 0; i < 16; i++) begin
            bus_read(A_DATA, rd);
            check("rx_drain", rd, {24'd0, rx_q.pop_front()});
        end
        bus_read(A_DATA, rd);   check("rx_empty_read_zero", rd, 32'h0);
        bus_read(A_STATUS, rd); check("rx_drained_status", rd, 32'h6);

        // Asynchronous reset in the middle of a TX frame
        mon_en = 1'b0;
        bus_write(A_DATA, 32'h00);
        idle(3);
        check("tx_low_before_reset", {31'd0, uart_tx}, 0);
        #2 rst = 1'b0;
        #1 check("async_reset_tx_high", {31'd0, uart_tx}, 1);
        check("async_reset_irq", {31'd0, irq}, 0);
        @(negedge clk); rst = 1'b1;
        bus_read(A_STATUS, rd); check("post_reset_status", rd, 32'h6);
        bus_read(A_BAUD, rd);   check("post_reset_bauddiv", rd, 32'd868);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
